// File: rtl/route_pkg.sv
// rtl/route_pkg.sv - shared state and opcode types for the route command controller
package route_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DWELL
  } state_t;

  typedef enum logic [1:0] {
    OP_STOP,
    OP_GO,
    OP_APPEND,
    OP_RESUME
  } opcode_t;

endpackage

// File: rtl/route_fifo.sv
// rtl/route_fifo.sv - destination queue; flush with a simultaneous push leaves one entry
module route_fifo #(
  parameter int ID_W   = 6,
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [ID_W-1:0]           din,
  output logic [ID_W-1:0]           head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(QDEPTH);

  logic [ID_W-1:0] mem [QDEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   wr_addr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign wr_addr = flush ? '0 : wr_ptr;
  assign do_push = push & (flush | ~full);
  assign do_pop  = pop & ~empty & ~flush;

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/route_cmd_ctrl.sv
// rtl/route_cmd_ctrl.sv - BLE-commanded station router with dwell stops; ROUTE_BUZZ_EN adds the obstacle buzzer
module route_cmd_ctrl #(
  parameter int ID_W      = 6,
  parameter int QDEPTH    = 4,
  parameter int DWELL_CYC = 50_000_000,
  parameter int BUZZ_DIV  = 12_500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                cmd,
  input  logic                      cmd_rdy,
  input  logic [7:0]                ID,
  input  logic                      ID_vld,
  input  logic                      OK2Move,
  output logic                      clr_cmd_rdy,
  output logic                      clr_ID_vld,
  output logic                      go,
  output logic                      in_transit,
  output logic                      arrived,
  output logic [$clog2(QDEPTH):0]   q_cnt,
  output logic                      q_ovf,
  output logic                      buzz,
  output logic                      buzz_n
);

  import route_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);

  state_t          state, state_nx;
  opcode_t         op;
  logic [DW-1:0]   dwell_cnt, dwell_nx;
  logic            ovf_nx;
  logic            arrived_nx;
  logic            q_push, q_pop, q_flush;
  logic            q_full, q_empty;
  logic [ID_W-1:0] q_head;
  logic            id_match;
  logic            unused_bits;

  assign op          = opcode_t'(cmd[7:6]);
  assign id_match    = (ID[ID_W-1:0] == q_head);
  assign clr_cmd_rdy = cmd_rdy;
  assign in_transit  = (state == MOVE);
  assign go          = OK2Move & in_transit;
  assign unused_bits = ^{cmd, ID};

  route_fifo #(
    .ID_W   (ID_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (q_flush),
    .din   (cmd[ID_W-1:0]),
    .head  (q_head),
    .count (q_cnt),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dwell_cnt <= '0;
      q_ovf     <= 1'b0;
      arrived   <= 1'b0;
    end else begin
      state     <= state_nx;
      dwell_cnt <= dwell_nx;
      q_ovf     <= ovf_nx;
      arrived   <= arrived_nx;
    end
  end

  // Dwell timing runs underneath any command; only STOP/GO/RESUME redirect the state.
  always_comb begin
    state_nx   = state;
    dwell_nx   = dwell_cnt;
    ovf_nx     = q_ovf;
    arrived_nx = 1'b0;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    q_flush    = 1'b0;
    clr_ID_vld = 1'b0;

    if (state == DWELL) begin
      if (dwell_cnt == '0) state_nx = MOVE;
      else                 dwell_nx = dwell_cnt - DW'(1);
    end

    if (cmd_rdy) begin
      case (op)
        OP_STOP: begin
          q_flush  = 1'b1;
          ovf_nx   = 1'b0;
          state_nx = IDLE;
        end
        OP_GO: begin
          q_flush  = 1'b1;
          q_push   = 1'b1;
          ovf_nx   = 1'b0;
          state_nx = MOVE;
        end
        OP_APPEND: begin
          if (q_full) ovf_nx = 1'b1;
          else        q_push = 1'b1;
        end
        OP_RESUME: begin
          if (state != MOVE && !q_empty) state_nx = MOVE;
        end
      endcase
    end else if (ID_vld) begin
      clr_ID_vld = 1'b1;
      if (state == MOVE && id_match) begin
        q_pop = 1'b1;
        if (q_cnt == CW'(1)) begin
          state_nx   = IDLE;
          arrived_nx = 1'b1;
        end else begin
          state_nx = DWELL;
          dwell_nx = DWELL_LOAD;
        end
      end
    end
  end

`ifdef ROUTE_BUZZ_EN
  localparam int BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

  logic [BW-1:0] buzz_cnt;
  logic          buzz_q;
  logic          buzz_on;

  assign buzz_on = in_transit & ~OK2Move;
  assign buzz    = buzz_on & buzz_q;
  assign buzz_n  = buzz_on & ~buzz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzz_cnt <= '0;
      buzz_q   <= 1'b0;
    end else if (!buzz_on) begin
      buzz_cnt <= '0;
      buzz_q   <= 1'b0;
    end else if (buzz_cnt == BW'(BUZZ_DIV - 1)) begin
      buzz_cnt <= '0;
      buzz_q   <= ~buzz_q;
    end else begin
      buzz_cnt <= buzz_cnt + BW'(1);
    end
  end
`else
  assign buzz   = 1'b0;
  assign buzz_n = 1'b0;
`endif

endmodule

// File: tb/tb_route_cmd_ctrl.sv
// tb/tb_route_cmd_ctrl.sv - directed and randomized checks of route_cmd_ctrl against a queue-level model
module tb_route_cmd_ctrl;

  localparam int ID_W      = 6;
  localparam int QDEPTH    = 4;
  localparam int DWELL_CYC = 5;
  localparam int BUZZ_DIV  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       OK2Move;
  logic       clr_cmd_rdy, clr_ID_vld, go, in_transit, arrived, q_ovf, buzz, buzz_n;
  logic [$clog2(QDEPTH):0] q_cnt;

  route_cmd_ctrl #(
    .ID_W      (ID_W),
    .QDEPTH    (QDEPTH),
    .DWELL_CYC (DWELL_CYC),
    .BUZZ_DIV  (BUZZ_DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .ID          (ID),
    .ID_vld      (ID_vld),
    .OK2Move     (OK2Move),
    .clr_cmd_rdy (clr_cmd_rdy),
    .clr_ID_vld  (clr_ID_vld),
    .go          (go),
    .in_transit  (in_transit),
    .arrived     (arrived),
    .q_cnt       (q_cnt),
    .q_ovf       (q_ovf),
    .buzz        (buzz),
    .buzz_n      (buzz_n)
  );

  always #10 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Model: mode 0 = stopped, 1 = travelling, 2 = dwelling at a station
  int mq[$];
  int mmode = 0;
  int mrem  = 0;
  bit movf  = 0;
  bit marr  = 0;
  int brun  = 0;
  bit drop_id = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic check_outputs();
    int e_bz, e_bzn;
    bit active;
    active = (mmode == 1) && !OK2Move;
`ifdef ROUTE_BUZZ_EN
    e_bz  = active ? ((brun / BUZZ_DIV) % 2) : 0;
    e_bzn = active ? 1 - e_bz : 0;
`else
    e_bz  = 0;
    e_bzn = 0;
`endif
    chk("in_transit",  in_transit,  (mmode == 1) ? 1 : 0);
    chk("go",          go,          ((mmode == 1) && OK2Move) ? 1 : 0);
    chk("clr_cmd_rdy", clr_cmd_rdy, cmd_rdy ? 1 : 0);
    chk("clr_ID_vld",  clr_ID_vld,  (ID_vld && !cmd_rdy) ? 1 : 0);
    chk("arrived",     arrived,     marr ? 1 : 0);
    chk("q_cnt",       q_cnt,       mq.size());
    chk("q_ovf",       q_ovf,       movf ? 1 : 0);
    chk("buzz",        buzz,        e_bz);
    chk("buzz_n",      buzz_n,      e_bzn);
  endtask

  task automatic model_step();
    int  nmode;
    bit  narr;
    int  d;
    nmode = mmode;
    narr  = 0;
    brun  = ((mmode == 1) && !OK2Move) ? brun + 1 : 0;
    if (mmode == 2) begin
      mrem--;
      if (mrem == 0) nmode = 1;
    end
    if (cmd_rdy) begin
      d = int'(cmd[ID_W-1:0]);
      case (cmd[7:6])
        2'd0: begin mq.delete(); movf = 0; nmode = 0; end
        2'd1: begin mq.delete(); mq.push_back(d); movf = 0; nmode = 1; end
        2'd2: begin
          if (mq.size() < QDEPTH) mq.push_back(d);
          else movf = 1;
        end
        default: if (mmode != 1 && mq.size() > 0) nmode = 1;
      endcase
    end else if (ID_vld) begin
      drop_id = 1;
      if (mmode == 1 && mq.size() > 0 && int'(ID[ID_W-1:0]) == mq[0]) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin nmode = 0; narr = 1; end
        else begin nmode = 2; mrem = DWELL_CYC; end
      end
    end
    mmode = nmode;
    marr  = narr;
  endtask

  task automatic tick(input bit crdy, input logic [7:0] c, input bit new_id,
                      input logic [7:0] idv, input bit okv);
    @(negedge clk);
    if (drop_id) begin ID_vld = 1'b0; drop_id = 0; end
    cmd_rdy = crdy;
    cmd     = c;
    if (new_id) begin ID_vld = 1'b1; ID = idv; end
    OK2Move = okv;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic idle(input bit okv);
    tick(0, 8'h00, 0, 8'h00, okv);
  endtask

  task automatic model_reset();
    mq.delete();
    mmode = 0; mrem = 0; movf = 0; marr = 0; brun = 0; drop_id = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_transit"}, in_transit, 0);
    chk({tag, "_go"},         go,         0);
    chk({tag, "_arrived"},    arrived,    0);
    chk({tag, "_q_cnt"},      q_cnt,      0);
    chk({tag, "_q_ovf"},      q_ovf,      0);
    chk({tag, "_clr_id"},     clr_ID_vld, 0);
    chk({tag, "_buzz"},       buzz,       0);
    chk({tag, "_buzz_n"},     buzz_n,     0);
  endtask

  initial begin
    bit         crdy, new_id, okv;
    logic [7:0] c, idv;
    int         r;

    rst_n = 1'b0; cmd = 8'h00; cmd_rdy = 1'b0; ID = 8'h00; ID_vld = 1'b0; OK2Move = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Single-stop trip: arrival pulse, back to stopped, queue empty
    tick(1, {2'b01, 6'd5}, 0, 8'h00, 1);
    tick(0, 8'h00, 1, 8'h05, 1);
    chk("trip1_clr_id", clr_ID_vld, 1);
    chk("trip1_moving", in_transit, 1);
    idle(1);
    chk("trip1_arrived", arrived, 1);
    chk("trip1_stopped", in_transit, 0);
    chk("trip1_q_cnt", q_cnt, 0);
    idle(1);
    chk("trip1_arrived_pulse", arrived, 0);

    // Intermediate stop dwells for exactly DWELL_CYC cycles; upper ID bits ignored
    tick(1, {2'b01, 6'd3}, 0, 8'h00, 1);
    tick(1, {2'b10, 6'd7}, 0, 8'h00, 1);
    tick(0, 8'h00, 1, 8'hC3, 1);
    chk("dwell_clr_id", clr_ID_vld, 1);
    for (int i = 0; i < DWELL_CYC; i++) begin
      idle(1);
      chk("dwell_stopped", in_transit, 0);
    end
    idle(1);
    chk("dwell_resumed", in_transit, 1);
    chk("dwell_q_cnt", q_cnt, 1);
    tick(0, 8'h00, 1, 8'h07, 1);
    idle(1);
    chk("dwell_arrived", arrived, 1);
    chk("dwell_idle", in_transit, 0);

    // Overflow on a full queue, cleared by STOP
    tick(1, {2'b01, 6'd1}, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) tick(1, {2'b10, 6'(i + 2)}, 0, 8'h00, 1);
    idle(1);
    chk("ovf_q_cnt", q_cnt, 4);
    chk("ovf_flag", q_ovf, 1);
    tick(1, {2'b00, 6'd0}, 0, 8'h00, 1);
    idle(1);
    chk("stop_q_cnt", q_cnt, 0);
    chk("stop_ovf", q_ovf, 0);
    chk("stop_idle", in_transit, 0);

    // Command and ID together: command wins, ID consumed the following cycle
    tick(1, {2'b01, 6'd5}, 0, 8'h00, 1);
    tick(1, {2'b10, 6'd9}, 1, 8'h05, 1);
    chk("prio_clr_cmd", clr_cmd_rdy, 1);
    chk("prio_clr_id_held", clr_ID_vld, 0);
    idle(1);
    chk("prio_clr_id_next", clr_ID_vld, 1);
    idle(1);
    chk("prio_dwell", in_transit, 0);
    chk("prio_q_cnt", q_cnt, 1);

    // Reset while dwelling discards the route
    idle(1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("rst_dwell");
    model_reset();
    ID_vld = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(1, {2'b11, 6'd0}, 0, 8'h00, 1);
    idle(1);
    chk("rst_resume_noop", in_transit, 0);
    tick(1, {2'b01, 6'd2}, 0, 8'h00, 1);
    idle(1);
    chk("rst_go_moves", in_transit, 1);

    // Blocked while travelling: no motion, buzzer active when enabled
    for (int i = 0; i < 3 * BUZZ_DIV; i++) begin
      idle(0);
      chk("blocked_go", go, 0);
    end
    idle(1);
    tick(1, {2'b00, 6'd0}, 0, 8'h00, 1);

    for (int n = 0; n < 4000; n++) begin
      crdy = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      c[7:6] = (r == 0) ? 2'd0 : (r <= 2) ? 2'd1 : (r <= 6) ? 2'd2 : 2'd3;
      c[5:0] = 6'($urandom_range(0, 7));
      new_id = ((!ID_vld || drop_id) && $urandom_range(0, 2) == 0);
      idv[7:6] = 2'($urandom_range(0, 3));
      idv[5:0] = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? 6'(mq[0])
                                                              : 6'($urandom_range(0, 7));
      okv = ($urandom_range(0, 5) != 0);
      tick(crdy, c, new_id, idv, okv);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
